boot_ctrl: RTL

//  Boot/run sequencer in front of the CPU. Receives a program as a byte stream,

---
 rtl/boot_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/boot_ctrl.sv
// Boot/run sequencer: loads a byte-streamed program into fetch memory,
// then releases the CPU and watches do_halt and a cycle watchdog.
module boot_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int MAX_CYCLES = 10000
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  input  logic              do_halt,
  output logic [1:0]        status,
  output logic [31:0]       run_cycles
);

  typedef enum logic [3:0] {
    S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
    S_START, S_RUN, S_HALTED, S_TIMEOUT, S_ERROR
  } state_e;

  localparam logic [32:0] CAP = 33'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       idx_q, idx_d;
  logic [7:0]        hi_q, hi_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [15:0]       n;
  logic              accept;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= S_LEN_HI;
      len_q   <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      S_LEN_HI, S_LEN_LO,
      S_DATA_HI, S_DATA_LO: in_ready = 1'b1;
      default:              in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign n      = {len_q[15:8], in_data};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      S_LEN_HI: if (accept) begin
        len_d   = {in_data, 8'h00};
        idx_d   = '0;
        state_d = S_LEN_LO;
      end
      S_LEN_LO: if (accept) begin
        len_d = n;
        if (n == 16'd0)                  state_d = S_START;
        else if ({17'd0, n} > CAP)       state_d = S_ERROR;
        else                             state_d = S_DATA_HI;
      end
      S_DATA_HI: if (accept) begin
        hi_d    = in_data;
        state_d = S_DATA_LO;
      end
      S_DATA_LO: if (accept) begin
        we_d    = 1'b1;
        addr_d  = ADDR_W'(idx_q);
        wdata_d = {hi_q, in_data};
        if (idx_q == len_q - 16'd1) begin
          state_d = S_START;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = S_DATA_HI;
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (cyc_q != 32'hFFFF_FFFF) cyc_d = cyc_q + 32'd1;
        // halt takes priority over a watchdog expiry in the same cycle
        if (do_halt)                          state_d = S_HALTED;
        else if (cyc_d == 32'(MAX_CYCLES))    state_d = S_TIMEOUT;
      end
      S_HALTED, S_TIMEOUT, S_ERROR: if (start) begin
        cyc_d   = '0;
        state_d = S_LEN_HI;
      end
      default: state_d = S_LEN_HI;
    endcase
  end

  always_comb begin
    status = 2'd0;
    unique case (state_q)
      S_RUN:              status = 2'd1;
      S_HALTED:           status = 2'd2;
      S_TIMEOUT, S_ERROR: status = 2'd3;
      default:            status = 2'd0;
    endcase
  end

  assign cpu_rst    = (state_q != S_RUN);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign run_cycles = cyc_q;

endmodule
